// File: rtl/imm_encoder_loader.sv
// rtl/imm_encoder_loader.sv - packs I/S/B-type fields and a 32-bit immediate into RV32I words and writes them to instruction memory
module imm_encoder_loader #(
    parameter int          D_WIDTH    = 32,
    parameter int          ADDR_WIDTH = 8,
    parameter int unsigned BASE_ADDR  = 0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [1:0]            req_fmt,
    input  logic [6:0]            req_op,
    input  logic [2:0]            req_funct3,
    input  logic [4:0]            req_rd,
    input  logic [4:0]            req_rs1,
    input  logic [4:0]            req_rs2,
    input  logic [31:0]           req_imm,
    input  logic                  req_last,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [D_WIDTH-1:0]    mem_wdata,
    input  logic                  mem_ready,
    output logic                  done,
    output logic                  err,
    output logic [7:0]            err_count
);

    localparam logic [ADDR_WIDTH-1:0] BASE = BASE_ADDR[ADDR_WIDTH-1:0];

    typedef enum logic [1:0] {IDLE, WRITE, REJECT, DONE} state_t;

    state_t             state;
    logic               last_q;
    logic [31:0]        enc;
    logic               legal;
    logic signed [31:0] imm_s;

    assign imm_s = req_imm;

    // Legality is judged on the full signed immediate so that out-of-range
    // values cannot alias into range after field truncation.
    always_comb begin
        enc   = '0;
        legal = 1'b0;
        case (req_fmt)
            2'd0: begin
                enc   = {req_imm[11:0], req_rs1, req_funct3, req_rd, req_op};
                legal = (imm_s >= -32'sd2048) && (imm_s <= 32'sd2047);
            end
            2'd1: begin
                enc   = {req_imm[11:5], req_rs2, req_rs1, req_funct3, req_imm[4:0], req_op};
                legal = (imm_s >= -32'sd2048) && (imm_s <= 32'sd2047);
            end
            2'd2: begin
                enc   = {req_imm[12], req_imm[10:5], req_rs2, req_rs1, req_funct3,
                         req_imm[4:1], req_imm[11], req_op};
                legal = (imm_s >= -32'sd4096) && (imm_s <= 32'sd4094) && !req_imm[0];
            end
            default: begin
                enc   = '0;
                legal = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            req_ready <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= BASE;
            mem_wdata <= '0;
            done      <= 1'b0;
            err       <= 1'b0;
            err_count <= 8'd0;
            last_q    <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (req_valid && req_ready) begin
                        req_ready <= 1'b0;
                        last_q    <= req_last;
                        if (legal) begin
                            mem_wdata <= enc;
                            mem_we    <= 1'b1;
                            state     <= WRITE;
                        end else begin
                            state <= REJECT;
                        end
                    end else begin
                        req_ready <= 1'b1;
                    end
                end
                WRITE: begin
                    if (mem_ready) begin
                        mem_we   <= 1'b0;
                        mem_addr <= mem_addr + ADDR_WIDTH'(4);
                        if (last_q) begin
                            done  <= 1'b1;
                            state <= DONE;
                        end else begin
                            req_ready <= 1'b1;
                            state     <= IDLE;
                        end
                    end
                end
                REJECT: begin
                    err <= 1'b1;
                    if (err_count != 8'hFF)
                        err_count <= err_count + 8'd1;
                    req_ready <= 1'b1;
                    state     <= IDLE;
                end
                DONE: begin
                    mem_addr  <= BASE;
                    req_ready <= 1'b1;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_imm_encoder_loader.sv
// tb/tb_imm_encoder_loader.sv - randomized self-checking bench for imm_encoder_loader against an arithmetic reference model
module tb_imm_encoder_loader;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [1:0]  req_fmt = '0;
    logic [6:0]  req_op = '0;
    logic [2:0]  req_funct3 = '0;
    logic [4:0]  req_rd = '0;
    logic [4:0]  req_rs1 = '0;
    logic [4:0]  req_rs2 = '0;
    logic [31:0] req_imm = '0;
    logic        req_last = 1'b0;
    logic        mem_we;
    logic [3:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ready = 1'b0;
    logic        done;
    logic        err;
    logic [7:0]  err_count;

    int n_checks = 0;
    int n_pass   = 0;
    int m_addr   = 0;
    int m_errs   = 0;

    imm_encoder_loader #(.D_WIDTH(32), .ADDR_WIDTH(4), .BASE_ADDR(0)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_fmt(req_fmt), .req_op(req_op), .req_funct3(req_funct3),
        .req_rd(req_rd), .req_rs1(req_rs1), .req_rs2(req_rs2),
        .req_imm(req_imm), .req_last(req_last),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ready(mem_ready), .done(done), .err(err), .err_count(err_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    function automatic logic [31:0] ref_word(input int fmt, input int unsigned op, f3, rd, rs1, rs2,
                                             input int imm, output bit ok);
        int unsigned u;
        int unsigned w;
        u = imm;
        w = 0;
        ok = 1'b0;
        if (fmt == 0) begin
            ok = (imm >= -2048) && (imm <= 2047);
            w = ((u & 32'hFFF) << 20) + (rs1 << 15) + (f3 << 12) + (rd << 7) + op;
        end else if (fmt == 1) begin
            ok = (imm >= -2048) && (imm <= 2047);
            w = (((u >> 5) & 127) << 25) + (rs2 << 20) + (rs1 << 15) + (f3 << 12)
              + ((u & 31) << 7) + op;
        end else if (fmt == 2) begin
            ok = (imm >= -4096) && (imm <= 4094) && (imm % 2 == 0);
            w = (((u >> 12) & 1) << 31) + (((u >> 5) & 63) << 25) + (rs2 << 20) + (rs1 << 15)
              + (f3 << 12) + (((u >> 1) & 15) << 8) + (((u >> 11) & 1) << 7) + op;
        end
        return w;
    endfunction

    task automatic wait_ready(output bit ok);
        int k;
        k = 0;
        while (req_ready !== 1'b1 && k < 20) begin
            @(posedge clk); #1;
            k++;
        end
        ok = (req_ready === 1'b1);
        if (!ok) check("ready_timeout", 32'(req_ready), 32'd1);
    endtask

    task automatic drive(input int fmt, input int unsigned op, f3, rd, rs1, rs2, input int imm, input bit last);
        req_fmt    = 2'(fmt);
        req_op     = 7'(op);
        req_funct3 = 3'(f3);
        req_rd     = 5'(rd);
        req_rs1    = 5'(rs1);
        req_rs2    = 5'(rs2);
        req_imm    = imm;
        req_last   = last;
        req_valid  = 1'b1;
        @(posedge clk); #1;
        req_valid  = 1'b0;
    endtask

    task automatic send(input int fmt, input int unsigned op, f3, rd, rs1, rs2,
                        input int imm, input bit last, input int stall);
        bit          ok;
        bit          rdy;
        logic [31:0] w;
        w = ref_word(fmt, op, f3, rd, rs1, rs2, imm, ok);
        wait_ready(rdy);
        if (!rdy) return;
        drive(fmt, op, f3, rd, rs1, rs2, imm, last);
        if (ok) begin
            check("we", 32'(mem_we), 32'd1);
            check("addr", 32'(mem_addr), 32'(m_addr));
            check("wdata", mem_wdata, w);
            repeat (stall) begin
                @(posedge clk); #1;
                check("hold_we", 32'(mem_we), 32'd1);
                check("hold_addr", 32'(mem_addr), 32'(m_addr));
                check("hold_wdata", mem_wdata, w);
                check("hold_ready", 32'(req_ready), 32'd0);
            end
            mem_ready = 1'b1;
            @(posedge clk); #1;
            mem_ready = 1'b0;
            check("we_drop", 32'(mem_we), 32'd0);
            m_addr = (m_addr + 4) % 16;
            if (last) begin
                check("done", 32'(done), 32'd1);
                check("ready_in_done", 32'(req_ready), 32'd0);
                m_addr = 0;
                @(posedge clk); #1;
                check("done_pulse", 32'(done), 32'd0);
                check("addr_base", 32'(mem_addr), 32'd0);
            end else begin
                check("no_done", 32'(done), 32'd0);
                check("ready_back", 32'(req_ready), 32'd1);
            end
        end else begin
            check("rej_we", 32'(mem_we), 32'd0);
            @(posedge clk); #1;
            m_errs = (m_errs < 255) ? m_errs + 1 : 255;
            check("err", 32'(err), 32'd1);
            check("err_count", 32'(err_count), 32'(m_errs));
            check("rej_done", 32'(done), 32'd0);
            check("rej_we2", 32'(mem_we), 32'd0);
        end
    endtask

    int edge_imm[12] = '{-4097, -4096, -4095, -2049, -2048, 2047, 2048, 4094, 4095, 4096, -4, 3};

    initial begin
        bit rdy;
        int imm;
        int sel;
        #12;
        check("rst_ready", 32'(req_ready), 32'd0);
        check("rst_we", 32'(mem_we), 32'd0);
        check("rst_addr", 32'(mem_addr), 32'd0);
        check("rst_wdata", mem_wdata, 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_errcnt", 32'(err_count), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Directed encodings with literal expected words.
        send(0, 'h13, 0, 1, 0, 0, 5, 1'b0, 0);
        check("i_word", mem_wdata, 32'h00500093);
        send(1, 'h23, 2, 0, 0, 2, 8, 1'b0, 0);
        check("s_word", mem_wdata, 32'h00202423);
        send(2, 'h63, 1, 0, 1, 2, -4, 1'b1, 0);
        check("b_word", mem_wdata, 32'hFE209EE3);
        send(0, 'h13, 0, 3, 4, 0, -1, 1'b0, 0);

        send(0, 'h13, 0, 1, 0, 0, 2048, 1'b0, 0);
        check("rej1_cnt", 32'(err_count), 32'd1);
        send(2, 'h63, 0, 0, 1, 2, 3, 1'b1, 0);
        check("rej2_cnt", 32'(err_count), 32'd2);
        send(3, 'h13, 0, 1, 1, 1, 0, 1'b0, 0);
        check("rej3_cnt", 32'(err_count), 32'd3);
        send(1, 'h23, 0, 0, 5, 6, -2048, 1'b0, 3);

        // Reset in the middle of a stalled write.
        wait_ready(rdy);
        if (rdy) begin
            drive(0, 'h13, 0, 2, 2, 0, 7, 1'b0);
            check("pre_rst_we", 32'(mem_we), 32'd1);
            #3 rst_n = 1'b0;
            #1 check("async_we", 32'(mem_we), 32'd0);
            @(posedge clk); #2;
            rst_n = 1'b1;
            m_addr = 0;
            m_errs = 0;
            #1 check("post_rst_err", 32'(err), 32'd0);
        end

        for (int i = 0; i < 5; i++)
            send(0, 'h13, 0, i, 0, 0, i, 1'b0, 0);
        check("wrap_addr", 32'(mem_addr), 32'd4);

        for (int i = 0; i < 80; i++) begin
            sel = $urandom_range(0, 2);
            if (sel == 0) imm = int'($urandom_range(0, 8191)) - 4096;
            else if (sel == 1) imm = edge_imm[$urandom_range(0, 11)];
            else imm = int'($urandom);
            send($urandom_range(0, 3), $urandom & 127, $urandom & 7, $urandom & 31,
                 $urandom & 31, $urandom & 31, imm, ($urandom_range(0, 7) == 0),
                 $urandom_range(0, 2));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
